// File: rtl/fetch_queue_unit_if.sv
// Bundle of the fetch unit's memory request/response, decode-side and redirect signals.
// Handshakes: a request transfers on a rising clock edge where imem_req_valid && imem_req_ready; a decode pop
// transfers where if_valid && id_ready; responses and redirects are single-cycle pulses with no backpressure.
interface fetch_queue_unit_if #(
    parameter int MAX_OUTSTANDING = 2
);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    logic             imem_req_valid;
    logic             imem_req_ready;
    logic [31:0]      imem_req_addr;
    logic             imem_resp_valid;
    logic [31:0]      imem_resp_instr;
    logic             if_valid;
    logic [31:0]      if_instr;
    logic [31:0]      if_pc;
    logic [31:0]      if_pc_4;
    logic             id_ready;
    logic             redirect_valid;
    logic [31:0]      redirect_target;
    logic [OUT_W-1:0] outstanding;
    logic [OUT_W-1:0] dbg_drop_count;

    modport master (
        output imem_req_valid, imem_req_addr,
        output if_valid, if_instr, if_pc, if_pc_4,
        output outstanding, dbg_drop_count,
        input  imem_req_ready, imem_resp_valid, imem_resp_instr,
        input  id_ready, redirect_valid, redirect_target
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        input  if_valid, if_instr, if_pc, if_pc_4,
        input  outstanding, dbg_drop_count,
        output imem_req_ready, imem_resp_valid, imem_resp_instr,
        output id_ready, redirect_valid, redirect_target
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited word requests and
// buffers tagged responses in a small queue for decode; redirects flush and drop stale responses.
module fetch_queue_unit #(
    parameter logic [31:0] TEXT_START      = 32'h0040_0000,
    parameter int          QUEUE_DEPTH     = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                clk,
    input  logic                rstn,
    fetch_queue_unit_if.master  bus
);
    localparam int          OUT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam int          CNT_W     = $clog2(QUEUE_DEPTH + 1);
    localparam int          PTR_W     = $clog2(QUEUE_DEPTH);
    localparam logic [31:0] MAX_OUT_U = 32'(MAX_OUTSTANDING);
    localparam logic [31:0] DEPTH_U   = 32'(QUEUE_DEPTH);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [OUT_W-1:0] outstanding_q, outstanding_d;
    logic [OUT_W-1:0] drop_count_q, drop_count_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      instr_mem_q [QUEUE_DEPTH];
    logic [31:0]      instr_mem_d [QUEUE_DEPTH];
    logic [31:0]      pc_mem_q [QUEUE_DEPTH];
    logic [31:0]      pc_mem_d [QUEUE_DEPTH];
    logic             run_q, run_d;
    logic             if_valid_q, if_valid_d;
    logic [31:0]      if_instr_q, if_instr_d;
    logic [31:0]      if_pc_q, if_pc_d;
    logic [31:0]      if_pc_4_q, if_pc_4_d;

    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             req_valid;
    logic             req_fire;
    logic             resp_ok;
    logic             push;
    logic             pop;
    logic [31:0]      head_instr;
    logic [31:0]      head_pc;

    // Credits count both in-flight requests and queued entries, so a response always has a slot.
    always_comb begin
        redirect    = bus.redirect_valid;
        redirect_pc = bus.redirect_target & ~32'h3;
        req_valid   = run_q && !redirect
                      && (32'(outstanding_q) < MAX_OUT_U)
                      && ((32'(outstanding_q) + 32'(count_q)) < DEPTH_U);
        req_fire    = req_valid && bus.imem_req_ready;
        resp_ok     = bus.imem_resp_valid && (outstanding_q != '0);
        push        = resp_ok && (drop_count_q == '0) && !redirect;
        pop         = if_valid_q && bus.id_ready && !redirect;
    end

    always_comb begin
        run_d         = 1'b1;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + OUT_W'(req_fire) - OUT_W'(resp_ok);
        drop_count_d  = drop_count_q;
        count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
        rd_ptr_d      = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d      = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        instr_mem_d   = instr_mem_q;
        pc_mem_d      = pc_mem_q;

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (push) begin
            instr_mem_d[wr_ptr_q] = bus.imem_resp_instr;
            pc_mem_d[wr_ptr_q]    = resp_pc_q;
            resp_pc_d             = resp_pc_q + 32'd4;
        end

        if (resp_ok && (drop_count_q != '0)) begin
            drop_count_d = drop_count_q - OUT_W'(1);
        end

        // Everything still in flight belongs to the old path; a response landing now is dropped too.
        if (redirect) begin
            fetch_pc_d   = redirect_pc;
            resp_pc_d    = redirect_pc;
            drop_count_d = outstanding_q - OUT_W'(resp_ok);
            count_d      = '0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
        end
    end

    // The head registers load the entry that will be at the front after this edge.
    always_comb begin
        head_instr = instr_mem_q[rd_ptr_d];
        head_pc    = pc_mem_q[rd_ptr_d];
        if (push && (rd_ptr_d == wr_ptr_q)) begin
            head_instr = bus.imem_resp_instr;
            head_pc    = resp_pc_q;
        end

        if_valid_d = (count_d != '0);
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_pc_4_d  = if_pc_4_q;
        if (count_d != '0) begin
            if_instr_d = head_instr;
            if_pc_d    = head_pc;
            if_pc_4_d  = head_pc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_q         <= 1'b0;
            fetch_pc_q    <= TEXT_START;
            resp_pc_q     <= TEXT_START;
            outstanding_q <= '0;
            drop_count_q  <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
            if_valid_q    <= 1'b0;
            if_instr_q    <= '0;
            if_pc_q       <= '0;
            if_pc_4_q     <= '0;
        end else begin
            run_q         <= run_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_count_q  <= drop_count_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            instr_mem_q   <= instr_mem_d;
            pc_mem_q      <= pc_mem_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            if_pc_4_q     <= if_pc_4_d;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.if_valid       = if_valid_q;
    assign bus.if_instr       = if_instr_q;
    assign bus.if_pc          = if_pc_q;
    assign bus.if_pc_4        = if_pc_4_q;
    assign bus.outstanding    = outstanding_q;
    assign bus.dbg_drop_count = drop_count_q;
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: in-order memory model with per-request latency, a consumed-instruction
// scoreboard, directed scenarios and a randomized phase.
module tb_fetch_queue_unit;
    localparam logic [31:0] TEXT_START = 32'h0040_0000;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } infl_t;

    logic clk;
    logic rstn;

    fetch_queue_unit_if #(.MAX_OUTSTANDING(2)) ifc ();

    fetch_queue_unit #(
        .TEXT_START(TEXT_START),
        .QUEUE_DEPTH(4),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (ifc)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model state ----------------
    infl_t       infl_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] exp_fetch_pc;
    int          cyc;
    int          lat_lo;
    int          lat_hi;
    bit          req_ready_k;
    bit          id_ready_k;
    int          n_vec;
    int          n_err;
    int          dut_fires;
    bit          cap_fire_armed;
    bit          cap_pop_armed;
    logic [31:0] cap_fire;
    logic [31:0] cap_pop;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic int stale_cnt();
        int n = 0;
        foreach (infl_q[i]) if (infl_q[i].stale) n++;
        return n;
    endfunction

    function automatic bit resp_due();
        return (infl_q.size() > 0) && (infl_q[0].due <= cyc);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic step(input bit redir, input logic [31:0] tgt);
        bit          resp_now;
        bit          exp_rv;
        bit          fire;
        bit          pop;
        infl_t       r;
        logic [63:0] e;
        @(negedge clk);
        check_eq("outstanding", 32'(ifc.outstanding), 32'(infl_q.size()));
        check_eq("drop_count", 32'(ifc.dbg_drop_count), 32'(stale_cnt()));
        check_eq("if_valid", 32'(ifc.if_valid), 32'(exp_q.size() != 0));

        resp_now            = resp_due();
        ifc.imem_resp_valid = resp_now;
        ifc.imem_resp_instr = resp_now ? instr_of(infl_q[0].addr) : 32'h0;
        ifc.imem_req_ready  = req_ready_k;
        ifc.id_ready        = id_ready_k;
        ifc.redirect_valid  = redir;
        ifc.redirect_target = redir ? tgt : 32'h0;
        #1;

        exp_rv = !redir && (infl_q.size() < 2) && ((infl_q.size() + exp_q.size()) < 4);
        check_eq("req_valid", 32'(ifc.imem_req_valid), 32'(exp_rv));
        if (ifc.imem_req_valid && req_ready_k) dut_fires++;
        fire = exp_rv && req_ready_k;
        if (fire) begin
            check_eq("req_addr", ifc.imem_req_addr, exp_fetch_pc);
            if (cap_fire_armed) begin
                cap_fire       = ifc.imem_req_addr;
                cap_fire_armed = 1'b0;
            end
        end

        pop = (exp_q.size() != 0) && id_ready_k && !redir;
        if (pop) begin
            e = exp_q.pop_front();
            check_eq("if_pc", ifc.if_pc, e[31:0]);
            check_eq("if_instr", ifc.if_instr, e[63:32]);
            check_eq("if_pc_4", ifc.if_pc_4, e[31:0] + 32'd4);
            if (cap_pop_armed) begin
                cap_pop       = ifc.if_pc;
                cap_pop_armed = 1'b0;
            end
        end

        if (resp_now) begin
            r = infl_q.pop_front();
            if (!r.stale && !redir) exp_q.push_back({instr_of(r.addr), r.addr});
        end

        if (fire) begin
            infl_q.push_back('{addr: exp_fetch_pc, due: cyc + $urandom_range(lat_hi, lat_lo), stale: 1'b0});
            exp_fetch_pc = exp_fetch_pc + 32'd4;
        end

        if (redir) begin
            exp_q.delete();
            foreach (infl_q[i]) infl_q[i].stale = 1'b1;
            exp_fetch_pc = tgt & ~32'h3;
        end

        @(posedge clk);
        cyc++;
    endtask

    task automatic drive_idle();
        ifc.imem_req_ready  = 1'b0;
        ifc.imem_resp_valid = 1'b0;
        ifc.imem_resp_instr = 32'h0;
        ifc.id_ready        = 1'b0;
        ifc.redirect_valid  = 1'b0;
        ifc.redirect_target = 32'h0;
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        rstn = 1'b0;
        drive_idle();
        #1;
        check_eq({tag, "_req_valid"}, 32'(ifc.imem_req_valid), 32'd0);
        check_eq({tag, "_if_valid"}, 32'(ifc.if_valid), 32'd0);
        check_eq({tag, "_if_instr"}, ifc.if_instr, 32'd0);
        check_eq({tag, "_if_pc"}, ifc.if_pc, 32'd0);
        check_eq({tag, "_if_pc_4"}, ifc.if_pc_4, 32'd0);
        check_eq({tag, "_outstanding"}, 32'(ifc.outstanding), 32'd0);
        check_eq({tag, "_drop"}, 32'(ifc.dbg_drop_count), 32'd0);
        infl_q.delete();
        exp_q.delete();
        exp_fetch_pc = TEXT_START;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic wait_outstanding_2(input string tag);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 32'h0);
            #1;
            if (ifc.outstanding == 2) break;
        end
        check_eq(tag, 32'(ifc.outstanding), 32'd2);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] held_addr;
        int          pre;
        bit          hit;
        n_vec = 0; n_err = 0; cyc = 0; dut_fires = 0;
        cap_fire_armed = 1'b0; cap_pop_armed = 1'b0;
        cap_fire = '0; cap_pop = '0;
        lat_lo = 1; lat_hi = 1;
        req_ready_k = 1'b1; id_ready_k = 1'b1;
        exp_fetch_pc = TEXT_START;
        rstn = 1'b0;
        drive_idle();

        // Reset then stream with 1-cycle latency.
        apply_reset("rst0");
        cap_pop_armed = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0);
        check_eq("stream_first_pc", cap_pop, 32'h0040_0000);

        // Decode stalled: exactly four requests, head holds, then drain and resume.
        apply_reset("rst1");
        id_ready_k = 1'b0;
        dut_fires = 0;
        for (int i = 0; i < 12; i++) step(1'b0, 32'h0);
        #1;
        check_eq("bp_issued", 32'(dut_fires), 32'd4);
        check_eq("bp_hold_pc", ifc.if_pc, 32'h0040_0000);
        check_eq("bp_hold_valid", 32'(ifc.if_valid), 32'd1);
        id_ready_k = 1'b1;
        cap_fire_armed = 1'b1;
        for (int i = 0; i < 15; i++) step(1'b0, 32'h0);
        check_eq("bp_resume_addr", cap_fire, 32'h0040_0010);

        // Redirect with two requests in flight at 3-cycle latency.
        apply_reset("rst2");
        lat_lo = 3; lat_hi = 3;
        wait_outstanding_2("redir_setup");
        cap_fire_armed = 1'b1;
        cap_pop_armed  = 1'b1;
        step(1'b1, 32'h0040_0103);
        #1;
        check_eq("redir_drop", 32'(ifc.dbg_drop_count), 32'd2);
        for (int i = 0; i < 15; i++) step(1'b0, 32'h0);
        check_eq("redir_first_addr", cap_fire, 32'h0040_0100);
        check_eq("redir_first_pc", cap_pop, 32'h0040_0100);

        // Redirect on the same edge as a response and a pop.
        lat_lo = 1; lat_hi = 1;
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (resp_due() && (exp_q.size() != 0)) begin
                hit = 1'b1;
                break;
            end
            step(1'b0, 32'h0);
        end
        check_eq("same_edge_setup", 32'(hit), 32'd1);
        pre = infl_q.size();
        step(1'b1, 32'h0040_0200);
        #2;
        check_eq("same_edge_drop", 32'(ifc.dbg_drop_count), 32'(pre - 1));
        check_eq("same_edge_outst", 32'(ifc.outstanding), 32'(pre - 1));
        check_eq("same_edge_empty", 32'(ifc.if_valid), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0);

        // Memory not ready: request holds, then a redirect withdraws it.
        req_ready_k = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0);
        #2;
        held_addr = ifc.imem_req_addr;
        check_eq("wait_valid_start", 32'(ifc.imem_req_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0);
            #2;
            check_eq("wait_addr", ifc.imem_req_addr, held_addr);
            check_eq("wait_valid", 32'(ifc.imem_req_valid), 32'd1);
        end
        step(1'b1, 32'h0040_0800);
        req_ready_k = 1'b1;
        cap_fire_armed = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0);
        check_eq("wait_redir_addr", cap_fire, 32'h0040_0800);

        // Reset mid-stream with two outstanding.
        lat_lo = 3; lat_hi = 3;
        wait_outstanding_2("rst_mid_setup");
        apply_reset("rst_mid");
        lat_lo = 1; lat_hi = 1;
        cap_fire_armed = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0);
        check_eq("rst_mid_restart", cap_fire, 32'h0040_0000);

        // Randomized traffic including redirects and address wrap.
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 400; i++) begin
            req_ready_k = ($urandom_range(0, 3) != 0);
            id_ready_k  = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 24) == 0) begin
                step(1'b1, (i % 3 == 0) ? 32'hFFFF_FFF6 : $urandom());
            end else begin
                step(1'b0, 32'h0);
            end
        end
        req_ready_k = 1'b1;
        id_ready_k  = 1'b1;
        for (int i = 0; i < 12; i++) step(1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the pipelined core's IF/ID register.
- Owns the fetch PC and issues word requests to a variable-latency instruction memory through a valid/ready request channel and an in-order response channel.
- Buffers returned instructions, each tagged with its PC and PC+4, in a small queue consumed by decode.
- Accepts a redirect (taken branch or jump resolved in ID) that flushes the queue and discards responses already in flight.

Parameters:
- TEXT_START, 'h00400000: PC value loaded at reset.
- QUEUE_DEPTH, 4: instruction queue entries; power of two, at least 2.
- MAX_OUTSTANDING, 2: maximum memory requests in flight; at least 1, at most QUEUE_DEPTH.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rstn  in  1  reset; asynchronous, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_resp_valid  in  1  one instruction returned, in request order; no backpressure.
- imem_resp_instr  in  32  returned instruction word.
- if_valid  out  1  queue head valid toward decode.
- if_instr  out  32  queue head instruction.
- if_pc  out  32  address of the queue head instruction.
- if_pc_4  out  32  if_pc + 4.
- id_ready  in  1  decode consumes the head when if_valid is also high.
- redirect_valid  in  1  one-cycle redirect pulse.
- redirect_target  in  32  new fetch PC; bits [1:0] forced to 0.
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  in-flight request count, including requests marked for drop.

Behaviour:
- Reset (rstn low, asynchronous) sets:
  - fetch_pc = resp_pc = TEXT_START.
  - Queue empty, outstanding = 0, drop_count = 0.
  - Outputs: imem_req_valid = 0, if_valid = 0, if_instr = 0, if_pc = 0, if_pc_4 = 0.
- The first request may be raised in the first cycle after rstn deasserts.
- Request issue:
  - imem_req_valid = !redirect_valid && outstanding < MAX_OUTSTANDING && (outstanding + queue_count) < QUEUE_DEPTH. This credit rule guarantees the queue never overflows.
  - imem_req_addr = fetch_pc.
  - On handshake (valid && ready): fetch_pc += 4 and outstanding increments.
  - Address and valid hold while waiting for ready. Redirect is the only event allowed to withdraw a pending request.
- Response handling:
  - Each imem_resp_valid decrements outstanding; a same-cycle issue and response net to zero.
  - If drop_count > 0, the response is discarded and drop_count decrements.
  - Otherwise the queue pushes {imem_resp_instr, resp_pc, resp_pc + 4} and resp_pc += 4.
  - imem_resp_valid while outstanding == 0 is a protocol error; the block ignores it.
- Decode side:
  - if_* reflect the queue head, registered. A response accepted at edge N is visible from edge N onward, so decode samples it at edge N+1 at the earliest; there is no combinational bypass.
  - Pop occurs when if_valid && id_ready.
  - if_* remain stable while if_valid && !id_ready.
  - Push and pop in the same cycle are allowed at any occupancy, including full.
- Redirect (redirect_valid high at edge N) has priority over everything else that cycle:
  - Queue cleared; any pop that cycle is ignored; if_valid = 0 after edge N.
  - fetch_pc = resp_pc = {redirect_target[31:2], 2'b00}.
  - No request issues that cycle.
  - drop_count = outstanding - (imem_resp_valid ? 1 : 0); the response arriving at edge N is itself discarded.
  - outstanding is updated normally.
  - The first request to the target issues in cycle N+1 if credits allow.
  - Back-to-back redirects: the last one wins, and drop counts accumulate correctly.
- Wrap-around:
  - fetch_pc and resp_pc wrap modulo 2^32.
  - Queue pointers wrap modulo QUEUE_DEPTH.
  - Full/empty is tracked by an occupancy count.

Test Plan:
- Reset then stream (req_ready = 1, 1-cycle response latency, id_ready = 1): if_pc reads 0x00400000, 0x00400004, 0x00400008 on consecutive cycles with matching instructions; if_pc_4 = if_pc + 4.
- Backpressure (id_ready = 0 after reset): exactly 4 requests issue (0x00400000..0x0040000C); imem_req_valid then stays 0 and if_* hold 0x00400000; raising id_ready drains the queue in order and refetch resumes at 0x00400010.
- Redirect with 2 in flight (3-cycle latency), redirect_target = 0x00400103: both stale responses are discarded; the next if_pc = 0x00400100 and the next request address is 0x00400100.
- Redirect on the same edge as a response and a pop: that response is discarded, the queue ends empty, and drop_count = outstanding - 1.
- req_ready held low for 5 cycles: imem_req_addr and imem_req_valid stay constant throughout; a redirect mid-wait withdraws the request, and the next address is the target.
- rstn pulsed low mid-stream with 2 outstanding: all outputs go to their reset values immediately; after release, fetching restarts at 0x00400000 with outstanding = 0.
